// File: rtl/sdr_rd_pkg.sv
// rtl/sdr_rd_pkg.sv - shared constants and types for the SDRAM read-data capture path
//
// Purpose : tag bit positions, capture FSM state encoding and FIFO entry sizing
//           shared by sdr_rd_capture and sdr_rd_fifo.
// Ports   : none (package).
package sdr_rd_pkg;

   // Delayed read tag layout: [3] beat valid, [2] last beat, [1:0] channel id
   localparam int TAG_VALID  = 3;
   localparam int TAG_LAST   = 2;
   localparam int TAG_ID_MSB = 1;
   localparam int TAG_ID_LSB = 0;

   // Each FIFO entry carries {id[1:0], last} on top of the data bits
   localparam int ENTRY_META_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } rd_state_t;

   function automatic int entry_width(input int dq_width);
      return dq_width + ENTRY_META_W;
   endfunction

endpackage

// File: rtl/sdr_rd_fifo.sv
// rtl/sdr_rd_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose : FWFT buffer; head entry is visible on rdata_o whenever empty_o=0.
//           rdata_o is forced to 0 while empty so no stale data leaks out.
// Ports   : clk, rst (async, active-high)
//           push_i, wdata_i[width] - write side; a push while full is dropped
//                                    unless a pop happens on the same edge
//           pop_i                  - advance head (ignored while empty)
//           rdata_o[width]         - head entry
//           full_o, empty_o        - occupancy status
module sdr_rd_fifo #(
   parameter int width = 19,
   parameter int aw    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int DEPTH = 2 ** aw;

   logic [aw:0]      wr_ptr_q;
   logic [aw:0]      rd_ptr_q;
   logic [width-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the addresses match
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[aw] != rd_ptr_q[aw]) &&
                    (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]);

   assign do_pop  = pop_i && !empty_o;
   // When full, a same-edge pop frees the slot the push lands in
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[aw-1:0]] <= wdata_i;
   end

   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[aw-1:0]];

endmodule

// File: rtl/sdr_rd_capture.sv
// rtl/sdr_rd_capture.sv - SDRAM read-data capture with burst framing check
//
// Purpose : samples DQ on every tagged beat from the delay line, checks burst
//           framing (channel id consistency, max burst length) and buffers
//           beats in a FWFT FIFO for the Wishbone-side read port.
// Ports   : clk, rst (async, active-high)
//           tag_i[4]          - {valid, last, id[1:0]} aligned with dq_i
//           dq_i[dq_width]    - SDRAM read data
//           rd_data_o, rd_id_o, rd_last_o, rd_valid_o, rd_ready_i
//                             - head-of-FIFO read port, valid/ready handshake
//           overflow_o        - sticky, beat dropped on full FIFO
//           frame_err_o       - sticky, burst framing violation
//           busy_o            - capture FSM is inside a burst
module sdr_rd_capture
   import sdr_rd_pkg::*;
#(
   parameter int dq_width  = 16,
   parameter int fifo_aw   = 3,
   parameter int max_burst = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          tag_i,
   input  logic [dq_width-1:0] dq_i,
   output logic [dq_width-1:0] rd_data_o,
   output logic [1:0]          rd_id_o,
   output logic                rd_last_o,
   output logic                rd_valid_o,
   input  logic                rd_ready_i,
   output logic                overflow_o,
   output logic                frame_err_o,
   output logic                busy_o
);

   localparam int EW = entry_width(dq_width);
   localparam int CW = $clog2(max_burst + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(max_burst);

   rd_state_t   state_q;
   logic [1:0]  id_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic        overflow_q;
   logic        frame_err_q;

   logic        beat_valid;
   logic        beat_last;
   logic [1:0]  beat_id;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;
   logic [EW-1:0] fifo_wdata;
   logic [EW-1:0] fifo_rdata;

   assign beat_valid = tag_i[TAG_VALID];
   assign beat_last  = tag_i[TAG_LAST];
   assign beat_id    = tag_i[TAG_ID_MSB:TAG_ID_LSB];

   assign fifo_wdata = {beat_id, beat_last, dq_i};
   assign fifo_pop   = rd_valid_o && rd_ready_i;

   sdr_rd_fifo #(
      .width (EW),
      .aw    (fifo_aw)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (beat_valid),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign rd_valid_o = !fifo_empty;
   assign rd_data_o  = fifo_rdata[dq_width-1:0];
   assign rd_last_o  = fifo_rdata[dq_width];
   assign rd_id_o    = fifo_rdata[dq_width+2:dq_width+1];

   assign cnt_d = cnt_q + 1'b1;

   // Framing is checked independently of FIFO acceptance: a dropped beat
   // still counts towards its burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         id_q        <= '0;
         cnt_q       <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (beat_valid && fifo_full && !fifo_pop) overflow_q <= 1'b1;

         if (beat_valid) begin
            case (state_q)
               ST_IDLE: begin
                  if (!beat_last) begin
                     if (max_burst == 1) begin
                        // A one-beat limit is exhausted by the first beat
                        frame_err_q <= 1'b1;
                     end else begin
                        state_q <= ST_BURST;
                        id_q    <= beat_id;
                        cnt_q   <= CW'(1);
                     end
                  end
               end
               ST_BURST: begin
                  if (beat_id != id_q) frame_err_q <= 1'b1;
                  if (beat_last) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end else if (cnt_d == MAX_CNT) begin
                     frame_err_q <= 1'b1;
                     state_q     <= ST_IDLE;
                     cnt_q       <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign overflow_o  = overflow_q;
   assign frame_err_o = frame_err_q;
   assign busy_o      = (state_q == ST_BURST);

endmodule

// File: tb/tb_sdr_rd_capture.sv
// tb/tb_sdr_rd_capture.sv - scoreboard bench for sdr_rd_capture
module tb_sdr_rd_capture;

   localparam int DQW   = 16;
   localparam int DEPTH = 8;
   localparam int MAXB  = 8;

   typedef struct packed {
      logic [1:0]     id;
      logic           last;
      logic [DQW-1:0] data;
   } ent_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     tag;
   logic [DQW-1:0] dq;
   logic           rdy;
   logic [DQW-1:0] rd_data_o;
   logic [1:0]     rd_id_o;
   logic           rd_last_o;
   logic           rd_valid_o;
   logic           overflow_o;
   logic           frame_err_o;
   logic           busy_o;

   sdr_rd_capture #(
      .dq_width  (DQW),
      .fifo_aw   (3),
      .max_burst (MAXB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tag_i       (tag),
      .dq_i        (dq),
      .rd_data_o   (rd_data_o),
      .rd_id_o     (rd_id_o),
      .rd_last_o   (rd_last_o),
      .rd_valid_o  (rd_valid_o),
      .rd_ready_i  (rdy),
      .overflow_o  (overflow_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state: contents of the buffer, sticky flags, burst tracking
   ent_t exp_q[$];
   logic exp_ovf;
   logic exp_ferr;
   logic in_burst;
   logic [1:0] burst_id;
   int   beats_seen;

   // What the upcoming clock edge will do, decided by the driver
   logic pend_push;
   logic pend_drop;
   logic pend_beat;
   ent_t pend_ent;
   logic mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      exp_ovf    = 1'b0;
      exp_ferr   = 1'b0;
      in_burst   = 1'b0;
      burst_id   = 2'd0;
      beats_seen = 0;
      pend_push  = 1'b0;
      pend_drop  = 1'b0;
      pend_beat  = 1'b0;
      pend_ent   = '0;
   endtask

   // Reference model advances on each edge using what the driver scheduled
   always @(posedge clk) begin
      if (!rst) begin
         if (pend_push) exp_q.push_back(pend_ent);
         if (pend_drop) exp_ovf = 1'b1;
         if (pend_beat) begin
            if (!in_burst) begin
               if (!pend_ent.last) begin
                  in_burst   = 1'b1;
                  burst_id   = pend_ent.id;
                  beats_seen = 1;
               end
            end else begin
               if (pend_ent.id != burst_id) exp_ferr = 1'b1;
               beats_seen++;
               if (pend_ent.last) in_burst = 1'b0;
               else if (beats_seen == MAXB) begin
                  exp_ferr = 1'b1;
                  in_burst = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: compares the presented head against the scoreboard mid-cycle
   always @(negedge clk) begin
      if (mon_en) begin
         chk("rd_valid", rd_valid_o, exp_q.size() > 0);
         if (exp_q.size() > 0) begin
            chk("rd_data", rd_data_o, exp_q[0].data);
            chk("rd_id",   rd_id_o,   exp_q[0].id);
            chk("rd_last", rd_last_o, exp_q[0].last);
            if (rdy) void'(exp_q.pop_front());
         end else begin
            chk("empty_outputs", {rd_data_o, rd_id_o, rd_last_o}, 0);
         end
         chk("overflow",  overflow_o,  exp_ovf);
         chk("frame_err", frame_err_o, exp_ferr);
         chk("busy",      busy_o,      in_burst);
      end
   end

   // Drive one cycle of stimulus; called at posedge+1
   task automatic step(input logic [3:0] t, input logic [DQW-1:0] d, input logic r);
      logic pop_now;
      tag = t;
      dq  = d;
      rdy = r;
      pop_now   = r && (exp_q.size() > 0);
      pend_beat = t[3];
      pend_ent  = '{id: t[1:0], last: t[2], data: d};
      pend_drop = t[3] && (exp_q.size() == DEPTH) && !pop_now;
      pend_push = t[3] && !pend_drop;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tag = 4'd0;
      rdy = 1'b0;
      model_clear();
      #1;
      chk("reset_outputs",
          {rd_valid_o, rd_data_o, rd_id_o, rd_last_o, overflow_o, frame_err_o, busy_o}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) step(4'b0000, 16'h0, r);
   endtask

   initial begin
      logic [1:0] cur_id;
      logic [3:0] rt;
      rst = 1'b1;
      tag = 4'd0;
      dq  = '0;
      rdy = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      do_reset();

      // Single beat
      step(4'b1101, 16'hA5A5, 1'b1);
      idle(3, 1'b1);

      // Burst of 4 on channel 2
      step(4'b1010, 16'd1, 1'b1);
      step(4'b1010, 16'd2, 1'b1);
      step(4'b1010, 16'd3, 1'b1);
      step(4'b1110, 16'd4, 1'b1);
      idle(3, 1'b1);

      // Backpressure: 9 beats, last on beat 9, nothing consumed
      for (int i = 1; i <= 8; i++) step(4'b1000, 16'(16'h100 + i), 1'b0);
      step(4'b1100, 16'h0109, 1'b0);
      idle(2, 1'b0);
      idle(10, 1'b1);

      // Full FIFO with a same-cycle push and pop
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(4'b1111, 16'(16'h200 + i), 1'b0);
      step(4'b1111, 16'h02FF, 1'b1);
      idle(2, 1'b0);
      idle(10, 1'b1);

      // Channel id switch mid-burst
      do_reset();
      step(4'b1000, 16'h0301, 1'b1);
      step(4'b1001, 16'h0302, 1'b1);
      step(4'b1100, 16'h0303, 1'b1);
      idle(3, 1'b1);

      // Eight beats without last
      do_reset();
      for (int i = 0; i < MAXB; i++) step(4'b1010, 16'(16'h400 + i), 1'b1);
      idle(3, 1'b1);

      // Reset in the middle of a burst with entries queued
      step(4'b1011, 16'h0501, 1'b0);
      step(4'b1011, 16'h0502, 1'b0);
      do_reset();
      step(4'b1110, 16'h0600, 1'b1);
      idle(3, 1'b1);

      // Randomised traffic with occasional resets
      cur_id = 2'd0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 600 == 599) do_reset();
         if ($urandom_range(0, 19) == 0) cur_id = 2'($urandom_range(0, 3));
         rt[3]   = ($urandom_range(0, 9) < 7);
         rt[2]   = ($urandom_range(0, 3) == 0);
         rt[1:0] = cur_id;
         step(rt, 16'($urandom), ($urandom_range(0, 9) < 6));
      end
      idle(DEPTH + 4, 1'b1);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
